// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 = dcache, m1 = icache) with burst lock and alternating priority.
// Optional stall watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
`ifndef RW
`define RW 16
`endif

module mem_bus_arbiter #(
  parameter int AW             = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_adr,
  input  logic [`RW-1:0]   m0_o_dat,
  input  logic [1:0]       m0_sel,
  output logic             m0_ack,
  output logic             m0_err,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_adr,
  input  logic [`RW-1:0]   m1_o_dat,
  input  logic [1:0]       m1_sel,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [`RW-1:0]   m_i_dat,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [AW-1:0]    wb_adr,
  output logic [`RW-1:0]   wb_o_dat,
  output logic [1:0]       wb_sel,
  input  logic [`RW-1:0]   wb_i_dat,
  input  logic             wb_ack,
  input  logic             wb_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [AW-1:0]    adr;
    logic [`RW-1:0]   dat;
    logic [1:0]       sel;
  } wb_req_t;

  wb_req_t [1:0] mreq;
  wb_req_t       req;
  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic          granted;
  logic          tmo;

  assign mreq[0] = {m0_cyc, m0_stb, m0_we, m0_adr, m0_o_dat, m0_sel};
  assign mreq[1] = {m1_cyc, m1_stb, m1_we, m1_adr, m1_o_dat, m1_sel};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // last_grant tracks every grant so contention always favours the master served less recently
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_nxt      = last_grant ? GNT0 : GNT1;
          last_grant_nxt = ~last_grant;
        end else if (m0_cyc) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc) state_nxt = IDLE;
      GNT1:    if (!m1_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign granted = (state != IDLE);
  assign req     = (state == GNT1) ? mreq[1] : mreq[0];

  always_comb begin
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_adr   = '0;
    wb_o_dat = '0;
    wb_sel   = 2'b11;
    if (granted) begin
      wb_cyc   = req.cyc;
      wb_stb   = req.stb & ~tmo;
      wb_we    = req.we;
      wb_adr   = req.adr;
      wb_o_dat = req.dat;
      wb_sel   = req.sel;
    end
  end

  assign m0_ack  = wb_ack & (state == GNT0);
  assign m1_ack  = wb_ack & (state == GNT1);
  assign m0_err  = (wb_err | tmo) & (state == GNT0);
  assign m1_err  = (wb_err | tmo) & (state == GNT1);
  assign m_i_dat = wb_i_dat;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = TIMEOUT_CYCLES[7:0];
  logic [7:0] stall_cnt;

  // On the limit cycle stb is withdrawn, so the slave cannot also complete the beat
  assign tmo = granted && (stall_cnt == TMO_LIM);

  always_ff @(posedge i_clk) begin
    if (i_rst || !granted || wb_ack || wb_err || tmo)
      stall_cnt <= '0;
    else if (wb_cyc && wb_stb)
      stall_cnt <= stall_cnt + 8'd1;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed protocol checks, then random two-master traffic
// scored against per-master expected-beat queues and an address-derived read-data model.
`ifndef RW
`define RW 16
`endif

module tb_mem_bus_arbiter;
  localparam int AW  = 24;
  localparam int TMO = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [AW-1:0]    m0_adr;
  logic [`RW-1:0]   m0_o_dat;
  logic [1:0]       m0_sel;
  logic             m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [AW-1:0]    m1_adr;
  logic [`RW-1:0]   m1_o_dat;
  logic [1:0]       m1_sel;
  logic [`RW-1:0]   m_i_dat;
  logic             wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]    wb_adr;
  logic [`RW-1:0]   wb_o_dat;
  logic [1:0]       wb_sel;
  logic [`RW-1:0]   wb_i_dat;
  logic             wb_ack, wb_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic sb_en   = 1'b0;
  int   stall_left = 0;

  typedef struct {
    logic [AW-1:0]  adr;
    logic           we;
    logic [`RW-1:0] dat;
    logic [1:0]     sel;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  always #5 i_clk = ~i_clk;

  mem_bus_arbiter #(.AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_o_dat(m0_o_dat), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_o_dat(m1_o_dat), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_i_dat(m_i_dat),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat), .wb_sel(wb_sel),
    .wb_i_dat(wb_i_dat), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  function automatic logic [`RW-1:0] rd_model(input logic [AW-1:0] a);
    return `RW'(a ^ (a >> 8) ^ 24'hA5C3E1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_o_dat = '0; m0_sel = 2'b11;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_o_dat = '0; m1_sel = 2'b11;
    wb_ack = 0; wb_err = 0; wb_i_dat = '0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    i_rst = 1;
    step();
    i_rst = 0;
  endtask

  // Slave model: random 0..2 stall cycles, occasional error, reads return rd_model(adr)
  always begin
    @(posedge i_clk); #2;
    if (sb_en) begin
      wb_ack   = 0;
      wb_err   = 0;
      wb_i_dat = `RW'($urandom);
      if (wb_cyc && wb_stb) begin
        if (stall_left > 0) stall_left--;
        else begin
          if ($urandom_range(9) == 0) wb_err = 1;
          else wb_ack = 1;
          if (!wb_we) wb_i_dat = rd_model(wb_adr);
          stall_left = $urandom_range(2);
        end
      end
    end
  end

  task automatic sb_pop(input int id);
    beat_t e;
    logic  err;
    n_tests++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL m%0d_spurious_term: got termination, required none (queue empty)", id);
    end else begin
      if (id == 0) begin e = q0.pop_front(); err = m0_err; end
      else         begin e = q1.pop_front(); err = m1_err; end
      if (wb_adr !== e.adr || wb_we !== e.we || wb_sel !== e.sel ||
          (e.we && wb_o_dat !== e.dat) ||
          (!e.we && !err && m_i_dat !== rd_model(e.adr))) begin
        n_fail++;
        $display("FAIL m%0d_beat: got adr=%h we=%b sel=%b wdat=%h rdat=%h, required adr=%h we=%b sel=%b wdat=%h rdat=%h",
                 id, wb_adr, wb_we, wb_sel, wb_o_dat, m_i_dat,
                 e.adr, e.we, e.sel, e.dat, rd_model(e.adr));
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (sb_en) begin
      n_tests++;
      if ((m0_ack | m0_err) && (m1_ack | m1_err)) begin
        n_fail++;
        $display("FAIL both_terminated: got m0 and m1 terminated together, required at most one");
      end
      if (m0_ack | m0_err) sb_pop(0);
      if (m1_ack | m1_err) sb_pop(1);
    end
  end

  task automatic run_master(input int id);
    beat_t e;
    int    len, bud;
    logic  ok;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(1, 3)) step();
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        e.adr = AW'($urandom);
        e.we  = 1'($urandom_range(1));
        e.dat = `RW'($urandom);
        e.sel = 2'($urandom_range(1, 3));
        if (id == 0) begin
          m0_cyc = 1; m0_stb = 1; m0_adr = e.adr; m0_we = e.we; m0_o_dat = e.dat; m0_sel = e.sel;
          q0.push_back(e);
        end else begin
          m1_cyc = 1; m1_stb = 1; m1_adr = e.adr; m1_we = e.we; m1_o_dat = e.dat; m1_sel = e.sel;
          q1.push_back(e);
        end
        bud = 0;
        ok  = 0;
        while (!ok && bud < 200) begin
          @(negedge i_clk);
          bud++;
          ok = (id == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
        end
        if (!ok) begin
          n_tests++;
          n_fail++;
          $display("FAIL m%0d_beat_timeout: got no termination in %0d cycles, required one", id, bud);
        end
        step();
      end
      if (id == 0) begin m0_cyc = 0; m0_stb = 0; end
      else         begin m1_cyc = 0; m1_stb = 0; end
    end
  endtask

  initial begin
    logic [`RW-1:0] rd;
    int errs;
    idle_inputs();
    i_rst = 1;
    step(); step();

    // Reset state, with stray slave responses that must not reach either master
    wb_ack = 1; wb_err = 1; wb_i_dat = 'h1234;
    smp();
    check("rst_wb_cyc", wb_cyc, 0);
    check("rst_wb_stb", wb_stb, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_adr", wb_adr, 0);
    check("rst_wb_o_dat", wb_o_dat, 0);
    check("rst_wb_sel", wb_sel, 2'b11);
    check("idle_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("idle_m_i_dat", m_i_dat, 'h1234);

    // Single m1 request: one cycle grant latency, ack routed to m1 only
    step();
    i_rst = 0; wb_ack = 0; wb_err = 0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 'h40; m1_sel = 2'b01; m0_adr = 'h777;
    smp(); check("lat_c0_cyc", wb_cyc, 0);
    step(); smp();
    check("lat_c1_cyc", wb_cyc, 1);
    check("lat_c1_adr", wb_adr, 'h40);
    check("lat_c1_sel", wb_sel, 2'b01);
    step(); smp(); check("stall_no_ack", m1_ack, 0);
    step(); wb_ack = 1; wb_i_dat = 'hbeef; smp();
    check("c3_acks", {m1_ack, m0_ack}, 2'b10);
    check("c3_m_i_dat", m_i_dat, 'hbeef);
    step(); wb_ack = 0; m1_cyc = 0; m1_stb = 0; smp();
    check("m1_drop_cyc", wb_cyc, 0);

    // Contention after reset: m0 first, IDLE gap, then m1, then alternation back to m0
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 'h100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 'h200;
    step(); smp(); check("arb_first_m0", wb_adr, 'h100);
    step(); m0_cyc = 0; m0_stb = 0; smp(); check("arb_m0_drop", wb_cyc, 0);
    step(); smp(); check("arb_idle_gap", wb_cyc, 0);
    step(); smp();
    check("arb_then_m1_adr", wb_adr, 'h200);
    check("arb_then_m1_cyc", wb_cyc, 1);
    step(); m1_cyc = 0; m1_stb = 0;
    step(); step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step(); smp(); check("arb_alternate_m0", wb_adr, 'h100);

    // m1 8-beat burst; m0 request at beat 3 must wait for the whole burst
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 'h400;
    for (int b = 0; b < 8; b++) begin
      step();
      m1_adr = AW'('h400 + b);
      wb_ack = 1;
      if (b == 3) begin m0_cyc = 1; m0_stb = 1; m0_adr = 'h900; end
      smp();
      check("burst_adr", wb_adr, 'h400 + b);
      check("burst_acks", {m1_ack, m0_ack}, 2'b10);
    end
    step(); wb_ack = 0; m1_cyc = 0; m1_stb = 0; smp(); check("burst_drop_cyc", wb_cyc, 0);
    step(); smp(); check("burst_idle_cyc", wb_cyc, 0);
    step(); smp(); check("burst_then_m0", wb_adr, 'h900);

    // m0 error on beat 2
    for (int b = 0; b < 3; b++) begin
      step();
      m0_adr = AW'('h900 + b);
      wb_ack = (b < 2);
      wb_err = (b == 2);
      rd = `RW'($urandom);
      wb_i_dat = rd;
      smp();
      if (b == 2) begin
        check("err_m0", {m0_err, m0_ack}, 2'b10);
        check("err_m1", m1_err, 0);
        check("err_m_i_dat", m_i_dat, rd);
      end else begin
        check("err_pre_ack", m0_ack, 1);
      end
    end

    // Stalled m0 with no slave response
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 'h55;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= TMO + 2; c++) begin
      step(); smp();
      check("tmo_err", m0_err, (c == TMO + 1));
      check("tmo_stb", wb_stb, (c != TMO + 1));
    end
`else
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      step(); smp();
      if (m0_err | m1_err) errs++;
    end
    check("no_tmo_err", errs, 0);
    check("stall_stb_held", wb_stb, 1);
`endif
    step(); m0_cyc = 0; m0_stb = 0;
    step(); step();

    // Reset during a GNT1 stall aborts the grant; late ack is not forwarded
    m1_cyc = 1; m1_stb = 1; m1_adr = 'h80;
    step(); smp(); check("rst_pre_gnt1", wb_cyc, 1);
    step(); i_rst = 1; smp();
    step(); i_rst = 0; wb_ack = 1; smp();
    check("rst_abort_cyc", wb_cyc, 0);
    check("rst_late_ack", m1_ack, 0);
    step(); wb_ack = 0; m1_cyc = 0; m1_stb = 0;
    step(); step();

    // Random two-master traffic against the scoreboard
    do_reset();
    sb_en = 1;
    fork
      run_master(0);
      run_master(1);
    join
    repeat (5) step();
    sb_en = 0;
    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter AW, default 24, Wishbone address width (master and upstream ports).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, stall-cycle limit before forced error; only used with MEM_ARB_TIMEOUT_EN.
REQ-003 i_clk  in  1  clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 m0_cyc, m0_stb, m0_we  in  1 each  master 0 (dcache) Wishbone control.
REQ-006 m0_adr  in  AW; m0_o_dat  in  `RW; m0_sel  in  2  master 0 address, write data, byte select.
REQ-007 m0_ack, m0_err  out  1 each  master 0 termination.
REQ-008 m1_cyc, m1_stb, m1_we  in  1 each; m1_adr  in  AW; m1_o_dat  in  `RW; m1_sel  in  2  master 1 (icache) port.
REQ-009 m1_ack, m1_err  out  1 each  master 1 termination.
REQ-010 m_i_dat  out  `RW  read data broadcast to both masters.
REQ-011 wb_cyc, wb_stb, wb_we  out  1; wb_adr  out  AW; wb_o_dat  out  `RW; wb_sel  out  2  upstream master port.
REQ-012 wb_i_dat  in  `RW; wb_ack, wb_err  in  1  upstream slave response.

Function
REQ-013 FSM states: IDLE, GNT0, GNT1.
REQ-014 IDLE: no request -> stay; only mN_cyc high -> GNTN next cycle; both high -> grant master other than last_grant, update last_grant.
REQ-015 GNTN: wb_cyc/stb/we/adr/o_dat/sel combinationally equal master N inputs; the other master's inputs ignored.
REQ-016 GNTN exits to IDLE the cycle after mN_cyc is sampled low; IDLE lasts at least one cycle between grants (no back-to-back grant switch).
REQ-017 Grant held for the whole mN_cyc assertion (burst lock, e.g. 8-beat icache line refill never interleaved).
REQ-018 mN_ack = wb_ack & (state==GNTN); mN_err = wb_err & (state==GNTN) (plus timeout error, REQ-025); non-granted master sees 0.
REQ-019 m_i_dat = wb_i_dat unconditionally; masters qualify by ack.
REQ-020 IDLE: wb_cyc, wb_stb, wb_we = 0; wb_adr, wb_o_dat = 0; wb_sel = 2'b11.
REQ-021 Arbitration latency: request sampled in IDLE -> upstream wb_cyc high exactly 1 cycle later.
REQ-022 Upstream ack/err while IDLE ignored (not forwarded).

Reset
REQ-023 i_rst: state IDLE, last_grant = 1 (master 0 wins first contention), timeout counter 0; all outputs per REQ-020, mN_ack/err = 0 from the next cycle.
REQ-024 i_rst mid-burst aborts the grant immediately; no ack delivered afterwards for that cycle.

Configuration
REQ-025 MEM_ARB_TIMEOUT_EN defined: 8-bit stall counter increments each cycle wb_cyc & wb_stb & ~wb_ack & ~wb_err; clears on ack/err, on IDLE, and on reset; when counter == TIMEOUT_CYCLES granted master gets mN_err for that one cycle, wb_stb forced 0 that cycle, counter clears.
REQ-026 MEM_ARB_TIMEOUT_EN undefined: no counter logic; errors originate only from wb_err; stalls wait indefinitely.

Verification
REQ-027 Only m1_cyc/stb raised at cycle 0, adr 0x000040 -> wb_cyc=1, wb_adr=0x000040 at cycle 1; wb_ack at cycle 3 -> m1_ack=1, m0_ack=0 at cycle 3.
REQ-028 After reset, m0 and m1 request same cycle -> GNT0 first; m0 drops cyc -> IDLE 1 cycle -> GNT1; repeat contention -> GNT0 (alternation).
REQ-029 m1 8-beat burst with cyc held, m0 requests at beat 3 -> no wb_adr change to m0 until all 8 m1 acks received and m1_cyc low.
REQ-030 Granted m0 with wb_err=1 at beat 2 -> m0_err=1 that cycle, m1_err=0, m_i_dat=wb_i_dat.
REQ-031 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, m0 granted, no ack -> m0_err pulse 4 stall cycles after first wb_stb, wb_stb=0 that cycle; undefined -> no err after 300 cycles.
REQ-032 i_rst asserted during GNT1 stall -> next cycle state IDLE, wb_cyc=0, late wb_ack not forwarded to m1.
